// File: rtl/pca_ctrl_pkg.sv
// Shared types and constants for the PCA-style PWM controller sleep/restart logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, default oscillator-settle and drain-timeout
// constants, the per-state output decode, and the timer width helper.
package pca_ctrl_pkg;

    // Encodings are visible on state_o and must stay fixed.
    typedef enum logic [2:0] {
        ST_SLEEP = 3'd0,
        ST_WAKE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } pca_state_e;

    // 500 us at 25 MHz.
    localparam int unsigned DEF_WAKE_CYCLES   = 12500;
    localparam int unsigned DEF_DRAIN_TIMEOUT = 65535;

    typedef struct packed {
        logic osc_en;
        logic hold;
    } pwr_ctrl_t;

    // Oscillator runs only once it has settled (RUN/DRAIN/HOLD); LED outputs are
    // held off whenever the PWM counter is not allowed to drive them.
    function automatic pwr_ctrl_t state_outputs(input pca_state_e st);
        pwr_ctrl_t o;
        o.osc_en = 1'b0;
        o.hold   = 1'b1;
        case (st)
            ST_RUN:   begin o.osc_en = 1'b1; o.hold = 1'b0; end
            ST_DRAIN: begin o.osc_en = 1'b1; o.hold = 1'b0; end
            ST_HOLD:  begin o.osc_en = 1'b1; o.hold = 1'b1; end
            default:  begin o.osc_en = 1'b0; o.hold = 1'b1; end
        endcase
        return o;
    endfunction

    // Bits needed for a down-counter shared by both timed states.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter with a zero flag.
// Latency: load/decrement take effect on the next rising edge; zero_o is a decode of the register.
// Backpressure: none; decrement requests at zero are ignored so the count never wraps.
//
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/load_val_i load
// a new count (load wins over decrement); dec_i decrement by one; zero_o count is 0.
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sleep_restart_ctrl.sv
// Sleep / oscillator-wake / drain / restart-hold sequencer for the PWM controller.
// Latency: all outputs registered and decoded from next state, so they change together with state_o.
// Backpressure: none; inputs are sampled every cycle, restart_wr_i only acts in HOLD.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   sleep_i           MODE1 SLEEP level
//   restart_wr_i      pulse: MODE1 write with RESTART=1
//   pwm_active_i      some channel is actively toggling
//   counter_wrap_i    pulse: prescaled counter wrapped 4095->0
//   osc_en_o          prescaler clock enable
//   hold_o            force LED outputs to output-disable value
//   restart_flag_o    MODE1 RESTART readback
//   state_o           current FSM state
module sleep_restart_ctrl
    import pca_ctrl_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES   = DEF_WAKE_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sleep_i,
    input  logic       restart_wr_i,
    input  logic       pwm_active_i,
    input  logic       counter_wrap_i,
    output logic       osc_en_o,
    output logic       hold_o,
    output logic       restart_flag_o,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_W = timer_width(WAKE_CYCLES, DRAIN_TIMEOUT);

    // The timer is loaded on entry with N-1 and the state is left on the cycle
    // it reads zero, giving a residency of exactly N cycles.
    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);

    pca_state_e       state_q, state_d;
    logic             restart_flag_q, restart_flag_d;
    logic             osc_en_q, osc_en_d;
    logic             hold_q, hold_d;
    pwr_ctrl_t        next_outs;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    cycle_timer #(
        .WIDTH (CNT_W)
    ) u_cycle_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        restart_flag_d = restart_flag_q;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
        tmr_dec        = 1'b0;

        case (state_q)
            ST_SLEEP: begin
                if (!sleep_i) begin
                    state_d      = ST_WAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = WAKE_LOAD;
                end
            end

            ST_WAKE: begin
                // Going back to sleep abandons the count; the reload on the next
                // SLEEP->WAKE entry restarts the full settle time.
                if (sleep_i) begin
                    state_d = ST_SLEEP;
                end else if (tmr_zero) begin
                    state_d = restart_flag_q ? ST_HOLD : ST_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_RUN: begin
                if (sleep_i) begin
                    if (pwm_active_i) begin
                        state_d      = ST_DRAIN;
                        tmr_load     = 1'b1;
                        tmr_load_val = DRAIN_LOAD;
                    end else begin
                        // Nothing is mid-period, so no restart is needed later.
                        state_d = ST_SLEEP;
                    end
                end
            end

            ST_DRAIN: begin
                if (!sleep_i) begin
                    state_d = ST_RUN;
                end else if (counter_wrap_i || tmr_zero) begin
                    // Sleeping with PWM active leaves channels mid-pattern; the
                    // flag lets firmware resume them via RESTART.
                    state_d        = ST_SLEEP;
                    restart_flag_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_HOLD: begin
                // sleep_i has priority; a simultaneous restart write is dropped.
                if (sleep_i) begin
                    state_d = ST_SLEEP;
                end else if (restart_wr_i) begin
                    state_d        = ST_RUN;
                    restart_flag_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_SLEEP;
            end
        endcase

        next_outs = state_outputs(state_d);
        osc_en_d  = next_outs.osc_en;
        hold_d    = next_outs.hold;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_SLEEP;
            restart_flag_q <= 1'b0;
            osc_en_q       <= 1'b0;
            hold_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            restart_flag_q <= restart_flag_d;
            osc_en_q       <= osc_en_d;
            hold_q         <= hold_d;
        end
    end

    assign osc_en_o       = osc_en_q;
    assign hold_o         = hold_q;
    assign restart_flag_o = restart_flag_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_sleep_restart_ctrl.sv
// Directed bench for sleep_restart_ctrl with WAKE_CYCLES=8, DRAIN_TIMEOUT=32.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sleep_restart_ctrl;

    localparam int unsigned WC = 8;
    localparam int unsigned DT = 32;

    logic       clk_i          = 1'b0;
    logic       rst_ni         = 1'b0;
    logic       sleep_i        = 1'b0;
    logic       restart_wr_i   = 1'b0;
    logic       pwm_active_i   = 1'b0;
    logic       counter_wrap_i = 1'b0;
    logic       osc_en_o;
    logic       hold_o;
    logic       restart_flag_o;
    logic [2:0] state_o;

    always #5 clk_i = ~clk_i;

    sleep_restart_ctrl #(
        .WAKE_CYCLES   (WC),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sleep_i        (sleep_i),
        .restart_wr_i   (restart_wr_i),
        .pwm_active_i   (pwm_active_i),
        .counter_wrap_i (counter_wrap_i),
        .osc_en_o       (osc_en_o),
        .hold_o         (hold_o),
        .restart_flag_o (restart_flag_o),
        .state_o        (state_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       s;
        logic       rw;
        logic       p;
        logic       w;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected {state, osc_en, hold, flag} for a given state and flag value.
    function automatic logic [5:0] exp_of(input int st, input logic f);
        logic osc;
        logic hld;
        osc = (st == 2) || (st == 3) || (st == 4);
        hld = (st == 0) || (st == 1) || (st == 4);
        return {3'(st), osc, hld, f};
    endfunction

    function automatic logic [5:0] obs();
        return {state_o, osc_en_o, hold_o, restart_flag_o};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic s, input logic rw, input logic p, input logic w);
        sleep_i        = s;
        restart_wr_i   = rw;
        pwm_active_i   = p;
        counter_wrap_i = w;
    endtask

    task automatic add(input logic s, input logic rw, input logic p, input logic w,
                       input int st, input logic f);
        vec_t v;
        v.s   = s;
        v.rw  = rw;
        v.p   = p;
        v.w   = w;
        v.exp = exp_of(st, f);
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;

        // Table starts in RUN with the flag clear.
        add(0, 1, 0, 0, 2, 0);                               // restart write in RUN ignored
        add(0, 0, 1, 1, 2, 0);                               // wrap in RUN ignored
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 3, 0);   // 5 DRAIN cycles
        add(1, 0, 1, 1, 0, 1);                               // wrap ends drain, flag set
        add(1, 1, 0, 0, 0, 1);                               // restart write in SLEEP ignored
        add(0, 0, 0, 0, 1, 1);                               // WAKE cycle 1
        add(0, 1, 0, 0, 1, 1);                               // restart write in WAKE ignored
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 1);   // WAKE cycles 3..8
        add(0, 0, 0, 0, 4, 1);                               // flag set -> HOLD
        add(0, 0, 0, 1, 4, 1);                               // wrap in HOLD ignored
        add(0, 1, 0, 0, 2, 0);                               // restart -> RUN, flag clear
        add(1, 0, 0, 0, 0, 0);                               // idle PWM -> straight to SLEEP
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0);   // WAKE cycles 1..4
        add(1, 0, 0, 0, 0, 0);                               // sleep mid-wake
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 0);   // full 8-cycle wake again
        add(0, 0, 0, 0, 2, 0);                               // flag clear -> RUN
        add(1, 0, 1, 0, 3, 0);
        add(1, 0, 1, 0, 3, 0);
        add(0, 0, 1, 0, 2, 0);                               // drain aborted, flag unchanged

        // Reset and release.
        drive(0, 0, 0, 0);
        #12;
        check("reset_state", 32'(obs()), 32'(exp_of(0, 0)));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check("release_no_edge", 32'(obs()), 32'(exp_of(0, 0)));
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("boot_wake_%0d", i), 32'(obs()), 32'(exp_of(1, 0)));
        end
        tick();
        check("boot_run", 32'(obs()), 32'(exp_of(2, 0)));

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].rw, tbl[i].p, tbl[i].w);
            tick();
            check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end

        // Drain with no wrap pulse: bounded count of DRAIN cycles.
        drive(1, 0, 1, 0);
        tick();
        cnt = 0;
        while ((state_o == 3'd3) && (cnt < 40)) begin
            cnt++;
            tick();
        end
        check("drain_timeout_len", 32'(cnt), 32'(DT));
        check("drain_timeout_sleep", 32'(obs()), 32'(exp_of(0, 1)));

        // Wake with the flag set lands in HOLD.
        drive(0, 0, 0, 0);
        repeat (WC + 1) tick();
        check("hold_after_wake", 32'(obs()), 32'(exp_of(4, 1)));

        // Sleep and restart write together in HOLD: sleep wins.
        drive(1, 1, 0, 0);
        tick();
        check("hold_sleep_wins", 32'(obs()), 32'(exp_of(0, 1)));

        // Reset mid-WAKE with the flag set.
        drive(0, 0, 0, 0);
        repeat (3) tick();
        check("mid_wake", 32'(obs()), 32'(exp_of(1, 1)));
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_wake", 32'(obs()), 32'(exp_of(0, 0)));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (WC + 1) tick();
        check("rerun_after_rst", 32'(obs()), 32'(exp_of(2, 0)));

        // Reset mid-DRAIN.
        drive(1, 0, 1, 0);
        repeat (3) tick();
        check("mid_drain", 32'(obs()), 32'(exp_of(3, 0)));
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_drain", 32'(obs()), 32'(exp_of(0, 0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
